mor1kx_branch_resolver: RTL and testbench
=========================================

MOR1KX_BRANCH_RESOLVER -- requirements
Module: mor1kx_branch_resolver

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32: PC width.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2: in-flight conditional-branch entries, legal range 1..4.
REQ-003 SHALL have parameter CNT_WIDTH, default 32: statistics counter width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port padv_decode_i  in  1  decode stage advances.
REQ-007 SHALL have port op_bf_i  in  1  decode holds l.bf.
REQ-008 SHALL have port op_bnf_i  in  1  decode holds l.bnf.
REQ-009 SHALL have port predicted_flag_i  in  1  predictor taken/not-taken for the decode branch.
REQ-010 SHALL have port decode_pc_i  in  OPTION_OPERAND_WIDTH  PC of the decode branch.
REQ-011 SHALL have port padv_execute_i  in  1  execute stage advances.
REQ-012 SHALL have port execute_brcond_i  in  1  conditional branch resolves in execute.
REQ-013 SHALL have port flag_i  in  1  architectural SR[F] at execute.
REQ-014 SHALL have port pipeline_flush_i  in  1  exception/external flush.
REQ-015 SHALL have port execute_op_bf_o  out  1  head entry is l.bf.
REQ-016 SHALL have port execute_op_bnf_o  out  1  head entry is l.bnf.
REQ-017 SHALL have port prev_op_brcond_o  out  1  one-cycle pulse after each resolve (predictor update strobe).
REQ-018 SHALL have port branch_mispredict_o  out  1  one-cycle mispredict pulse.
REQ-019 SHALL have port mispredict_pc_o  out  OPTION_OPERAND_WIDTH  PC of the mispredicted branch.
REQ-020 SHALL have port stall_o  out  1  queue full; decode must hold.
REQ-021 SHALL have port underflow_err_o  out  1  sticky: resolve with empty queue.
REQ-022 SHALL have ports brn_count_o and mispred_count_o  out  CNT_WIDTH  resolved-branch and mispredict counts.

Function
REQ-023 SHALL push entry {type (bf/bnf), predicted_flag_i, decode_pc_i} when padv_decode_i && (op_bf_i || op_bnf_i) && !stall_o; op_bf_i && op_bnf_i together SHALL store type bf.
REQ-024 SHALL drive stall_o = (occupancy == QUEUE_DEPTH), combinational from registered occupancy; a push attempted while full SHALL be ignored, with no state change.
REQ-025 SHALL resolve (pop head) when padv_execute_i && execute_brcond_i && occupancy != 0.
REQ-026 SHALL compute actual_taken = (type bf && flag_i) || (type bnf && !flag_i); mispredict = actual_taken != head predicted flag.
REQ-027 SHALL register the resolve: prev_op_brcond_o = 1 in the cycle after a resolve; branch_mispredict_o = 1 in that cycle only if mispredicted; otherwise 0.
REQ-028 SHALL load mispredict_pc_o with the head PC on a mispredicting resolve and hold it until the next mispredict.
REQ-029 SHALL, on a mispredicting resolve, clear the whole queue (occupancy 0), discarding any same-cycle push.
REQ-030 SHALL, for a correct resolve with a simultaneous push, pop and push in the same cycle with net occupancy unchanged; this is legal when full because stall_o is evaluated before the pop.
REQ-031 SHALL drive execute_op_bf_o/execute_op_bnf_o from the head entry type when occupancy != 0, else 0.
REQ-032 SHALL, on pipeline_flush_i, clear the queue next cycle with no mispredict, prev_op_brcond_o or counter update; pipeline_flush_i SHALL take priority over push and resolve in the same cycle.
REQ-033 SHALL, on padv_execute_i && execute_brcond_i with occupancy 0, set underflow_err_o, which stays 1 until reset; the queue and counters SHALL be unchanged.
REQ-034 SHALL increment brn_count_o per resolve and mispred_count_o per mispredict; both SHALL saturate at all-ones with no wrap.
REQ-035 SHALL store the queue as a circular buffer with read/write pointers wrapping modulo QUEUE_DEPTH.

Reset
REQ-036 SHALL, while rst = 0, asynchronously force occupancy, pointers, counters, underflow_err_o, prev_op_brcond_o, branch_mispredict_o and mispredict_pc_o to 0.
REQ-037 SHALL discard all in-flight entries when reset is asserted mid-operation; outputs SHALL be 0 from the first cycle after deassertion.

Verification
REQ-038 SHALL cover: push bf, pred=1, PC=0x100; resolve with flag_i=1 -> next cycle prev_op_brcond_o=1, branch_mispredict_o=0, brn_count_o=1.
REQ-039 SHALL cover: push bnf, pred=1, PC=0x200; resolve with flag_i=1 -> branch_mispredict_o=1, mispredict_pc_o=0x200, mispred_count_o=1, queue empty.
REQ-040 SHALL cover: two pushes (depth 2) -> stall_o=1; a third push is ignored; a correct resolve plus a push in the same cycle -> stall_o stays 1, and the PC order of the entries is preserved.
REQ-041 SHALL cover: two entries queued with the head mispredicting and a same-cycle push -> occupancy 0 and stall_o=0 next cycle.
REQ-042 SHALL cover: resolve with empty queue -> underflow_err_o=1, counters 0; it stays 1 until rst=0.
REQ-043 SHALL cover: CNT_WIDTH=4 with 17 correct resolves -> brn_count_o=15; pipeline_flush_i together with a resolve -> no pulses and queue empty.

Source files
------------

// File: rtl/mor1kx_branch_resolver_if.sv
// Decode/execute-side signal bundle for the conditional-branch resolver.
// The pipeline drives through the master modport, and the resolver sits on the slave modport.
interface mor1kx_branch_resolver_if #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned CNT_WIDTH            = 32
);
  logic                            padv_decode_i;
  logic                            op_bf_i;
  logic                            op_bnf_i;
  logic                            predicted_flag_i;
  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i;
  logic                            padv_execute_i;
  logic                            execute_brcond_i;
  logic                            flag_i;
  logic                            pipeline_flush_i;
  logic                            execute_op_bf_o;
  logic                            execute_op_bnf_o;
  logic                            prev_op_brcond_o;
  logic                            branch_mispredict_o;
  logic [OPTION_OPERAND_WIDTH-1:0] mispredict_pc_o;
  logic                            stall_o;
  logic                            underflow_err_o;
  logic [CNT_WIDTH-1:0]            brn_count_o;
  logic [CNT_WIDTH-1:0]            mispred_count_o;

  modport master (
    output padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i, decode_pc_i,
    output padv_execute_i, execute_brcond_i, flag_i, pipeline_flush_i,
    input  execute_op_bf_o, execute_op_bnf_o, prev_op_brcond_o, branch_mispredict_o,
    input  mispredict_pc_o, stall_o, underflow_err_o, brn_count_o, mispred_count_o
  );

  modport slave (
    input  padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i, decode_pc_i,
    input  padv_execute_i, execute_brcond_i, flag_i, pipeline_flush_i,
    output execute_op_bf_o, execute_op_bnf_o, prev_op_brcond_o, branch_mispredict_o,
    output mispredict_pc_o, stall_o, underflow_err_o, brn_count_o, mispred_count_o
  );
endinterface

// File: rtl/mor1kx_branch_resolver.sv
// Tracks in-flight l.bf/l.bnf branches between decode and execute in a small circular queue.
// It resolves them against SR[F], flags mispredicts, and keeps saturating statistics.
module mor1kx_branch_resolver #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH          = 2,
  parameter int unsigned CNT_WIDTH            = 32
) (
  input logic                     clk,
  input logic                     rst,
  mor1kx_branch_resolver_if.slave bus
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(QUEUE_DEPTH + 1);

  // Queue storage: type (1 = l.bf, 0 = l.bnf), predicted flag, PC
  logic                            r_type_bf [QUEUE_DEPTH];
  logic                            r_pred    [QUEUE_DEPTH];
  logic [OPTION_OPERAND_WIDTH-1:0] r_pc      [QUEUE_DEPTH];

  logic [PtrW-1:0]                 r_rd_ptr;
  logic [PtrW-1:0]                 r_wr_ptr;
  logic [OccW-1:0]                 r_occ;

  logic                            r_prev_brcond;
  logic                            r_mispredict;
  logic [OPTION_OPERAND_WIDTH-1:0] r_mispredict_pc;
  logic                            r_underflow;
  logic [CNT_WIDTH-1:0]            r_brn_count;
  logic [CNT_WIDTH-1:0]            r_mispred_count;

  logic                            w_full;
  logic                            w_empty;
  logic                            w_flush;
  logic                            w_brcond;
  logic                            w_resolve;
  logic                            w_underflow;
  logic                            w_push_req;
  logic                            w_push;
  logic                            w_head_bf;
  logic                            w_head_pred;
  logic [OPTION_OPERAND_WIDTH-1:0] w_head_pc;
  logic                            w_taken;
  logic                            w_mispredict;
  logic [PtrW-1:0]                 w_rd_ptr_inc;
  logic [PtrW-1:0]                 w_wr_ptr_inc;

  // Decode of push/resolve/mispredict conditions from registered queue state
  always_comb begin
    w_full       = (r_occ == OccW'(QUEUE_DEPTH));
    w_empty      = (r_occ == '0);
    w_flush      = bus.pipeline_flush_i;
    w_brcond     = bus.padv_execute_i && bus.execute_brcond_i;
    w_resolve    = w_brcond && !w_empty;
    w_underflow  = w_brcond && w_empty;
    w_head_bf    = r_type_bf[r_rd_ptr];
    w_head_pred  = r_pred[r_rd_ptr];
    w_head_pc    = r_pc[r_rd_ptr];
    w_taken      = w_head_bf ? bus.flag_i : !bus.flag_i;
    w_mispredict = w_resolve && (w_taken != w_head_pred);
    w_push_req   = bus.padv_decode_i && (bus.op_bf_i || bus.op_bnf_i);
    // A full queue still accepts a push when a correct resolve frees the head slot in the same
    // cycle; a mispredict discards the push along with the rest of the queue.
    w_push       = w_push_req && !w_mispredict && (!w_full || w_resolve);
    w_rd_ptr_inc = (r_rd_ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);
    w_wr_ptr_inc = (r_wr_ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
  end

  // Pointer and occupancy update; flush and mispredict both empty the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (w_flush || w_mispredict) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_resolve) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      if (w_push && !w_resolve) begin
        r_occ <= r_occ + OccW'(1);
      end else if (!w_push && w_resolve) begin
        r_occ <= r_occ - OccW'(1);
      end
    end
  end

  // Entry write at the tail
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        r_type_bf[i] <= 1'b0;
        r_pred[i]    <= 1'b0;
        r_pc[i]      <= '0;
      end
    end else if (w_push && !w_flush) begin
      r_type_bf[r_wr_ptr] <= bus.op_bf_i;
      r_pred[r_wr_ptr]    <= bus.predicted_flag_i;
      r_pc[r_wr_ptr]      <= bus.decode_pc_i;
    end
  end

  // Registered resolve strobes, mispredict PC, sticky underflow and saturating counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_brcond   <= 1'b0;
      r_mispredict    <= 1'b0;
      r_mispredict_pc <= '0;
      r_underflow     <= 1'b0;
      r_brn_count     <= '0;
      r_mispred_count <= '0;
    end else begin
      r_prev_brcond <= w_resolve && !w_flush;
      r_mispredict  <= w_mispredict && !w_flush;
      if (w_mispredict && !w_flush) begin
        r_mispredict_pc <= w_head_pc;
      end
      if (w_underflow && !w_flush) begin
        r_underflow <= 1'b1;
      end
      if (w_resolve && !w_flush && (r_brn_count != '1)) begin
        r_brn_count <= r_brn_count + CNT_WIDTH'(1);
      end
      if (w_mispredict && !w_flush && (r_mispred_count != '1)) begin
        r_mispred_count <= r_mispred_count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.stall_o             = w_full;
  assign bus.execute_op_bf_o     = !w_empty && w_head_bf;
  assign bus.execute_op_bnf_o    = !w_empty && !w_head_bf;
  assign bus.prev_op_brcond_o    = r_prev_brcond;
  assign bus.branch_mispredict_o = r_mispredict;
  assign bus.mispredict_pc_o     = r_mispredict_pc;
  assign bus.underflow_err_o     = r_underflow;
  assign bus.brn_count_o         = r_brn_count;
  assign bus.mispred_count_o     = r_mispred_count;

endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// Bench for mor1kx_branch_resolver: directed scenarios followed by randomized traffic, all
// checked against a queue-based reference model and a resolve scoreboard.
module tb_mor1kx_branch_resolver;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mor1kx_branch_resolver_if #(.OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(CW)) bus ();

  mor1kx_branch_resolver #(
    .OPTION_OPERAND_WIDTH(W),
    .QUEUE_DEPTH         (DEPTH),
    .CNT_WIDTH           (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { bit bf; bit pred; logic [W-1:0] pc; } entry_t;
  typedef struct { bit mis; logic [W-1:0] pc; } resp_t;

  entry_t      mq[$];   // model of in-flight branches, head first
  resp_t       sb[$];   // expected resolve responses
  int unsigned m_brn;
  int unsigned m_mis;
  bit          m_uf;
  logic [W-1:0] m_pc;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_brn = 0;
    m_mis = 0;
    m_uf  = 1'b0;
    m_pc  = '0;
  endtask

  task automatic model_step(input bit pd, bf, bnf, pred, input logic [W-1:0] pc,
                            input bit pe, brc, flg, fl);
    bit     full;
    bit     brcond;
    bit     mis;
    bit     taken;
    entry_t h;
    full = (mq.size() == DEPTH);
    if (fl) begin
      mq.delete();
    end else begin
      brcond = pe && brc;
      mis    = 1'b0;
      if (brcond && mq.size() == 0) m_uf = 1'b1;
      if (brcond && mq.size() != 0) begin
        h     = mq.pop_front();
        taken = h.bf ? flg : !flg;
        mis   = (taken != h.pred);
        if (m_brn < CMAX) m_brn++;
        if (mis) begin
          if (m_mis < CMAX) m_mis++;
          m_pc = h.pc;
          mq.delete();
        end
        sb.push_back('{mis, h.pc});
        full = 1'b0;  // head slot freed this cycle
      end
      if (pd && (bf || bnf) && !mis && !full) mq.push_back('{bf, pred, pc});
    end
  endtask

  task automatic drive(input bit pd, bf, bnf, pred, input logic [W-1:0] pc,
                       input bit pe, brc, flg, fl);
    bus.padv_decode_i    = pd;
    bus.op_bf_i          = bf;
    bus.op_bnf_i         = bnf;
    bus.predicted_flag_i = pred;
    bus.decode_pc_i      = pc;
    bus.padv_execute_i   = pe;
    bus.execute_brcond_i = brc;
    bus.flag_i           = flg;
    bus.pipeline_flush_i = fl;
  endtask

  task automatic cycle(input bit pd, bf, bnf, pred, input logic [W-1:0] pc,
                       input bit pe, brc, flg, fl);
    @(negedge clk);
    drive(pd, bf, bnf, pred, pc, pe, brc, flg, fl);
    model_step(pd, bf, bnf, pred, pc, pe, brc, flg, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops the scoreboard on every cycle and compares all outputs with the model
  always @(posedge clk) begin : monitor
    resp_t r;
    bit    eb;
    bit    en;
    #1;
    if (sb.size() != 0) begin
      r = sb.pop_front();
      chk("resolve_pulse", bus.prev_op_brcond_o, 1);
      chk("mispredict_pulse", bus.branch_mispredict_o, r.mis);
      if (r.mis) chk("mispredict_pc_at_pulse", bus.mispredict_pc_o, r.pc);
    end else begin
      chk("no_resolve_pulse", bus.prev_op_brcond_o, 0);
      chk("no_mispredict_pulse", bus.branch_mispredict_o, 0);
    end
    eb = 1'b0;
    en = 1'b0;
    if (mq.size() != 0) begin
      eb = mq[0].bf;
      en = !mq[0].bf;
    end
    chk("stall", bus.stall_o, mq.size() == DEPTH);
    chk("execute_op_bf", bus.execute_op_bf_o, eb);
    chk("execute_op_bnf", bus.execute_op_bnf_o, en);
    chk("underflow_err", bus.underflow_err_o, m_uf);
    chk("brn_count", bus.brn_count_o, m_brn);
    chk("mispred_count", bus.mispred_count_o, m_mis);
    chk("mispredict_pc", bus.mispredict_pc_o, m_pc);
  end

  initial begin
    int sel;
    drive(0, 0, 0, 0, '0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("reset_brn_count", bus.brn_count_o, 0);
    chk("reset_stall", bus.stall_o, 0);

    // l.bf predicted taken, flag set: correct
    cycle(1, 1, 0, 1, 32'h100, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, '0, 1, 1, 1, 0);
    after_edge();
    chk("bf_ok_prev_op_brcond", bus.prev_op_brcond_o, 1);
    chk("bf_ok_no_mispredict", bus.branch_mispredict_o, 0);
    chk("bf_ok_brn_count", bus.brn_count_o, 1);
    idle(1);

    // l.bnf predicted taken, flag set: mispredict
    cycle(1, 0, 1, 1, 32'h200, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, '0, 1, 1, 1, 0);
    after_edge();
    chk("bnf_mis_pulse", bus.branch_mispredict_o, 1);
    chk("bnf_mis_pc", bus.mispredict_pc_o, 32'h200);
    chk("bnf_mis_count", bus.mispred_count_o, 1);
    chk("bnf_mis_queue_empty", bus.execute_op_bnf_o, 0);
    idle(1);

    // Fill, ignored push while full, pop+push while full, order check via mispredict PC
    cycle(1, 1, 0, 0, 32'h300, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 32'h304, 0, 0, 0, 0);
    after_edge();
    chk("full_stall", bus.stall_o, 1);
    cycle(1, 1, 0, 0, 32'h308, 0, 0, 0, 0);
    after_edge();
    chk("full_push_ignored_stall", bus.stall_o, 1);
    cycle(1, 1, 0, 0, 32'h30c, 1, 1, 0, 0);
    after_edge();
    chk("pop_push_full_stall", bus.stall_o, 1);
    cycle(0, 0, 0, 0, '0, 1, 1, 0, 0);
    after_edge();
    chk("second_pop_ok", bus.branch_mispredict_o, 0);
    chk("second_pop_stall", bus.stall_o, 0);
    cycle(0, 0, 0, 0, '0, 1, 1, 1, 0);
    after_edge();
    chk("order_mis_pc", bus.mispredict_pc_o, 32'h30c);
    idle(1);

    // Head mispredicts with a same-cycle push: everything discarded
    cycle(1, 1, 0, 1, 32'h400, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 32'h404, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 32'h408, 1, 1, 0, 0);
    after_edge();
    chk("mis_clear_pc", bus.mispredict_pc_o, 32'h400);
    chk("mis_clear_stall", bus.stall_o, 0);
    chk("mis_clear_op_bf", bus.execute_op_bf_o, 0);
    idle(2);

    // Underflow is sticky until reset
    do_reset();
    cycle(0, 0, 0, 0, '0, 1, 1, 0, 0);
    after_edge();
    chk("underflow_set", bus.underflow_err_o, 1);
    chk("underflow_brn_count", bus.brn_count_o, 0);
    chk("underflow_mispred_count", bus.mispred_count_o, 0);
    idle(3);
    chk("underflow_sticky", bus.underflow_err_o, 1);
    do_reset();
    chk("underflow_cleared", bus.underflow_err_o, 0);

    // 17 correct resolves saturate a 4-bit counter at 15
    cycle(1, 1, 0, 1, 32'h500, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) cycle(1, 1, 0, 1, 32'h500 + 32'(4 * i), 1, 1, 1, 0);
    cycle(0, 0, 0, 0, '0, 1, 1, 1, 0);
    after_edge();
    chk("brn_count_saturated", bus.brn_count_o, 15);
    idle(1);

    // Flush beats a same-cycle resolve and push
    cycle(1, 1, 0, 1, 32'h600, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 32'h604, 1, 1, 0, 1);
    after_edge();
    chk("flush_no_prev_op_brcond", bus.prev_op_brcond_o, 0);
    chk("flush_no_mispredict", bus.branch_mispredict_o, 0);
    chk("flush_queue_empty", bus.execute_op_bf_o, 0);
    chk("flush_brn_count_held", bus.brn_count_o, 15);
    idle(1);

    // Randomized traffic with occasional mid-operation reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 3);
        cycle($urandom_range(0, 9) < 6, sel == 1 || sel == 3, sel == 2 || sel == 3,
              1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc,
              $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 99) < 3);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
